getir_denetleyici: RTL and testbench
====================================

Name: getir_denetleyici

Overview:
- Fetch-stage controller that sequences the program counter and drives the instruction-memory request/response handshake.
- Buffers fetched instructions in a small FIFO toward decode, so a decode stall does not stall memory mid-transaction.
- Accepts branch/jump redirects that flush buffered and in-flight instructions.
- Sits between the PC/fetch datapath, instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- redirect_i  in  1  branch/jump taken; flush and load a new PC.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_o  out  1  instruction-memory request valid.
- imem_addr_o  out  32  request address, equal to the current PC.
- imem_gnt_i  in  1  memory accepted the request this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- inst_valid_o  out  1  FIFO head valid toward decode.
- inst_o  out  32  FIFO head instruction.
- inst_pc_o  out  32  PC of the FIFO head instruction.
- inst_ready_i  in  1  decode accepts the head this cycle.

Behaviour:
- Reset values: state IDLE; pc = RESET_PC; FIFO empty; drop flag 0; imem_req_o = 0; inst_valid_o = 0; inst_o = 0; inst_pc_o = 0. Reset mid-transaction discards everything, including any outstanding response.
- Memory contract: at most one outstanding request. rvalid arrives at least 1 cycle after gnt, in order. gnt and rvalid never refer to the same request in the same cycle.
- State IDLE: imem_req_o = 0. Move to REQ when the free-space condition holds.
  - Free space: fifo_count + outstanding < FIFO_DEPTH.
- State REQ: imem_req_o = 1, imem_addr_o = pc.
  - On gnt: pc <= pc + 4 (modulo 2^32, wraps FFFF_FFFC -> 0000_0000), record the request PC, move to WAIT.
  - Without gnt: address held stable, except on redirect.
- State WAIT: imem_req_o = 0. On rvalid:
  - If drop = 0, push {rdata, recorded PC} to the FIFO.
  - If drop = 1, discard the data and clear drop.
  - Next state is REQ if free space remains after the push, otherwise IDLE.
- Decode side:
  - inst_valid_o = FIFO not empty.
  - Pop on inst_valid_o & inst_ready_i.
  - Push and pop in the same cycle are allowed when the FIFO is full.
  - Head outputs are stable while inst_valid_o & !inst_ready_i.
- Redirect, same cycle, priority over all other events:
  - pc <= {redirect_pc_i[31:2], 2'b00}.
  - FIFO flushed; inst_valid_o = 0 next cycle.
  - Any pop that cycle is ignored.
  - In WAIT without rvalid: drop <= 1, stay in WAIT.
  - In WAIT with rvalid: the response is discarded (not pushed), next state REQ.
  - In REQ with gnt: the old-PC request is accepted, drop <= 1, move to WAIT. The redirect PC is not incremented.
  - In REQ without gnt: imem_addr_o shows the redirect PC from the next cycle; imem_req_o stays high.
  - In IDLE: move to REQ.
- Back-to-back redirects: the latest one wins; drop stays 1. Only one response is ever outstanding, so a single flag is enough.
- Latency:
  - Reset release to first imem_req_o: 1 clock edge.
  - rvalid to inst_valid_o: 1 cycle (registered FIFO write).
  - Redirect to imem_req_o at the new PC: 1 cycle, when no request is outstanding.

Decomposition:
- Shared package getir_pkg:
  - Controller state enum (IDLE, REQ, WAIT).
  - RESET_PC default.
  - INST_W = 32 and ADDR_W = 32.
  - PC increment constant (4).
- Sub-module getir_fifo: synchronous FIFO of {pc, instruction} with a flush input, count output, and async reset. The controller instantiates one.

Test Plan:
- Reset, gnt tied 1, rvalid 1 cycle after gnt, inst_ready_i = 1 -> requests at addresses 0, 4, 8, 12; inst_o/inst_pc_o deliver words in order with PCs 0, 4, 8, 12.
- inst_ready_i = 0 throughout -> exactly FIFO_DEPTH = 2 requests (0, 4), then IDLE with imem_req_o = 0. After ready = 1 for 1 cycle -> request 8 issued.
- Redirect to 32'h0000_0103 while in WAIT for address 4 -> the address-4 response is dropped; the next request is 32'h0000_0100; inst_pc_o never shows 4.
- Redirect to 0x200 in the same cycle as a gnt for 0x10 -> the 0x10 response is discarded; the next request is 0x200; the FIFO is empty after the redirect.
- Gnt held 0 for 5 cycles in REQ -> imem_req_o = 1 and imem_addr_o stable for all 5 cycles; pc unchanged.
- pc = FFFF_FFFC granted -> next request 0000_0000. rst_i asserted in WAIT -> all outputs return to reset values immediately, and the late rvalid is ignored after release.

Source files
------------

// File: rtl/getir_pkg.sv
// Shared definitions for the fetch-stage controller.
//   - state_e       : controller states (IDLE / REQ / WAIT)
//   - fetch_entry_t : one instruction-buffer entry {pc, instruction}
//   - INST_W/ADDR_W : datapath widths
//   - RESET_PC_DEF  : default PC after reset
//   - PC_INC        : sequential fetch stride in bytes
package getir_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_INC       = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/getir_fifo.sv
// Synchronous instruction buffer between fetch and decode.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   flush_i        : drop all entries (wins over push/pop in the same cycle)
//   push_i         : write push_data_i (accepted when not full, or when
//                    full and a pop happens in the same cycle)
//   push_data_i    : {pc, instruction} entry
//   pop_i          : remove the head entry (ignored when empty)
//   head_o         : head entry, valid whenever count_o != 0
//   count_o        : number of stored entries, 0..DEPTH
module getir_fifo
  import getir_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic full;
  logic empty;
  logic do_pop;
  logic do_push;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i & ~empty;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; the count gates validity, and the top masks
  // the head outputs to zero while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/getir_denetleyici.sv
// Fetch-stage controller: sequences the PC, runs the single-outstanding
// instruction-memory handshake and buffers fetched words toward decode.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   redirect_i          : branch/jump taken; flushes and loads redirect_pc_i
//   redirect_pc_i       : redirect target (low two bits forced to zero)
//   imem_req_o          : request valid (registered, high only in REQ)
//   imem_addr_o         : request address (current PC)
//   imem_gnt_i          : memory accepted the request this cycle
//   imem_rvalid_i       : read data valid
//   imem_rdata_i        : instruction word
//   inst_valid_o        : buffer head valid toward decode
//   inst_o, inst_pc_o   : buffer head instruction and its PC (zero when empty)
//   inst_ready_i        : decode accepts the head this cycle
module getir_denetleyici
  import getir_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;   // PC of the request currently outstanding
  logic              drop_q;     // outstanding response belongs to a flushed path
  logic              req_q;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              rsp_fire;
  logic              push;
  logic              pop;
  logic              free_now;
  logic              free_after;
  logic [ADDR_W-1:0] redirect_pc;
  logic              unused_redirect_lsbs;

  assign redirect_pc          = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign rsp_fire = (state_q == ST_WAIT) & imem_rvalid_i;
  // A redirect discards both the arriving response and the decode pop.
  assign push     = rsp_fire & ~drop_q & ~redirect_i;
  assign pop      = inst_valid_o & inst_ready_i & ~redirect_i;

  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  // Nothing is outstanding in IDLE, nor in WAIT once the response has landed,
  // so the free-space test reduces to comparing the buffer count alone.
  assign free_now   = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign free_after = (count_next < CNT_W'(FIFO_DEPTH));

  assign push_entry = '{pc: req_pc_q, inst: imem_rdata_i};

  getir_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Controller FSM. req_q is updated together with the state so that
  // imem_req_o is a flop output that equals (state == REQ).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      req_q    <= 1'b0;
    end else if (redirect_i) begin
      pc_q <= redirect_pc;
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: begin
          if (imem_gnt_i) begin
            // The old-path request is already on its way; mark it to be dropped.
            req_pc_q <= pc_q;
            drop_q   <= 1'b1;
            state_q  <= ST_WAIT;
            req_q    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            drop_q  <= 1'b0;
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (free_now) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_gnt_i) begin
            pc_q     <= pc_q + PC_INC;
            req_pc_q <= pc_q;
            state_q  <= ST_WAIT;
            req_q    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            drop_q <= 1'b0;
            if (free_after) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = (fifo_count != '0);
  assign inst_o       = inst_valid_o ? fifo_head.inst : '0;
  assign inst_pc_o    = inst_valid_o ? fifo_head.pc   : '0;

endmodule

// File: tb/tb_getir_denetleyici.sv
// Self-checking bench for getir_denetleyici: a behavioural instruction memory,
// a transaction monitor, a cycle table for the buffer-full / redirect
// sequence and directed sequences for the remaining corner cases.
module tb_getir_denetleyici;
  import getir_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  getir_denetleyici #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents: distinct from the address so PC/data swaps are visible.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory responder (drives at negedge) ----------------
  bit          gnt_en     = 1'b1;
  int          resp_delay = 0;
  bit          keep_late  = 1'b0;   // let a pre-reset response arrive late
  bit          pend       = 1'b0;
  int          pend_cnt   = 0;
  logic [31:0] pend_addr  = '0;

  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i && !keep_late) pend = 1'b0;
      imem_rvalid_i = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = word_of(pend_addr);
          pend          = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      imem_gnt_i = gnt_en && imem_req_o && !rst_i;
      if (imem_gnt_i) begin
        pend      = 1'b1;
        pend_cnt  = resp_delay;
        pend_addr = imem_addr_o;
      end
    end
  end

  // ---------------- monitor (samples 2 time units after negedge) ----------
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];

  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i) begin
        if (imem_req_o && imem_gnt_i) req_log.push_back(imem_addr_o);
        if (inst_valid_o && inst_ready_i && !redirect_i) begin
          dlv_pc.push_back(inst_pc_o);
          dlv_inst.push_back(inst_o);
        end
      end
    end
  end

  function automatic int count_dlv(input int base, input logic [31:0] pc);
    int n = 0;
    for (int i = base; i < dlv_pc.size(); i++) if (dlv_pc[i] == pc) n++;
    return n;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, imem_req_o},   32'd0);
    check({tag, "_addr"},  imem_addr_o,           32'h0000_0000);
    check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
    check({tag, "_inst"},  inst_o,                32'd0);
    check({tag, "_pc"},    inst_pc_o,             32'd0);
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int n = 0;
    while (!(imem_req_o && imem_addr_o == a) && n < 60) begin
      tick();
      n++;
    end
    check(name, imem_req_o ? imem_addr_o : 32'hFFFF_FFFF, a);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int br;
    int bd;

    // Buffer fills with decode stalled, drains one entry, then a redirect
    // arrives while a response lands (response discarded, pop ignored).
    //            ready redir rpc           req  addr          valid pc
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h0000_0004};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0043, 1'b0, 32'h0,        1'b1, 32'h0000_0004};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0040, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040};

    // ---- 1: streaming fetch with decode always ready ----
    gnt_en = 1'b1; resp_delay = 0;
    do_reset();
    inst_ready_i = 1'b1;
    br = req_log.size();
    bd = dlv_pc.size();
    tick();
    check("s1_first_req",  {31'b0, imem_req_o}, 32'd1);
    check("s1_first_addr", imem_addr_o, 32'h0000_0000);
    repeat (20) tick();
    check("s1_nreq", {31'b0, (req_log.size() - br) >= 4}, 32'd1);
    check("s1_ndlv", {31'b0, (dlv_pc.size()  - bd) >= 4}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s1_req%0d", i),  req_log[br+i],  32'(4*i));
      check($sformatf("s1_pc%0d", i),   dlv_pc[bd+i],   32'(4*i));
      check($sformatf("s1_inst%0d", i), dlv_inst[bd+i], word_of(32'(4*i)));
    end

    // ---- 2: table-driven stall / drain / redirect ----
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("s2_v%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        check($sformatf("s2_v%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
      check($sformatf("s2_v%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].exp_valid});
      check($sformatf("s2_v%0d_pc", i), inst_pc_o, vecs[i].exp_pc);
      check($sformatf("s2_v%0d_inst", i), inst_o,
            vecs[i].exp_valid ? word_of(vecs[i].exp_pc) : 32'h0);
      inst_ready_i  = vecs[i].ready;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
    end
    redirect_i = 1'b0;

    // ---- 3: redirect while waiting for the address-4 response ----
    resp_delay = 2;
    do_reset();
    inst_ready_i = 1'b1;
    br = req_log.size();
    bd = dlv_pc.size();
    wait_req(32'h4, "s3_req4");
    tick();
    check("s3_in_wait", {31'b0, imem_req_o}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    check("s3_drop_wait", {31'b0, imem_req_o}, 32'd0);
    wait_req(32'h100, "s3_req100");
    repeat (20) tick();
    check("s3_log_after4", req_log[br+2], 32'h0000_0100);
    check("s3_no_pc4",     32'(count_dlv(bd, 32'h4)), 32'd0);
    check("s3_dlv0",       dlv_pc[bd],   32'h0000_0000);
    check("s3_dlv1",       dlv_pc[bd+1], 32'h0000_0100);
    check("s3_dlv1_inst",  dlv_inst[bd+1], word_of(32'h100));

    // ---- 4: redirect in the same cycle as the gnt for 0x10 ----
    resp_delay = 0;
    do_reset();
    inst_ready_i = 1'b1;
    br = req_log.size();
    bd = dlv_pc.size();
    wait_req(32'h10, "s4_req10");
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick();
    redirect_i = 1'b0;
    check("s4_fifo_empty", {31'b0, inst_valid_o}, 32'd0);
    check("s4_wait",       {31'b0, imem_req_o},   32'd0);
    tick();
    check("s4_req200",     imem_req_o ? imem_addr_o : 32'hFFFF_FFFF, 32'h0000_0200);
    repeat (10) tick();
    check("s4_log_after10", req_log[br+5], 32'h0000_0200);
    check("s4_no_pc10",     32'(count_dlv(bd, 32'h10)), 32'd0);
    check("s4_no_pcC",      32'(count_dlv(bd, 32'hC)),  32'd0);
    check("s4_dlv200",      32'(count_dlv(bd, 32'h200)), 32'd1);

    // ---- 5: gnt withheld in REQ, then redirect without gnt ----
    gnt_en = 1'b0;
    do_reset();
    inst_ready_i = 1'b1;
    br = req_log.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s5_hold%0d_req", i),  {31'b0, imem_req_o}, 32'd1);
      check($sformatf("s5_hold%0d_addr", i), imem_addr_o, 32'h0000_0000);
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0302;
    tick();
    redirect_i = 1'b0;
    check("s5_redir_req",  {31'b0, imem_req_o}, 32'd1);
    check("s5_redir_addr", imem_addr_o, 32'h0000_0300);
    gnt_en = 1'b1;
    wait_req(32'h304, "s5_req304");
    check("s5_log0", req_log[br],   32'h0000_0300);
    check("s5_nlog", 32'(req_log.size() - br), 32'd1);

    // ---- 6: PC wrap, then reset while waiting with a late response ----
    gnt_en = 1'b0;
    do_reset();
    inst_ready_i = 1'b1;
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    check("s6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    br = req_log.size();
    resp_delay = 3;
    gnt_en     = 1'b1;
    wait_req(32'h0, "s6_wrap_req0");
    gnt_en    = 1'b0;
    keep_late = 1'b1;
    check("s6_log_top", req_log[br], 32'hFFFF_FFFC);
    tick();
    check("s6_in_wait", {31'b0, imem_req_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("s6_async");
    tick();
    rst_i = 1'b0;
    bd = dlv_pc.size();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("s6_late%0d_valid", i), {31'b0, inst_valid_o}, 32'd0);
      check($sformatf("s6_late%0d_addr", i),  imem_addr_o, 32'h0000_0000);
    end
    keep_late  = 1'b0;
    resp_delay = 0;
    gnt_en     = 1'b1;
    repeat (10) tick();
    check("s6_ndlv",   {31'b0, (dlv_pc.size() - bd) >= 1}, 32'd1);
    check("s6_dlv0",   dlv_pc[bd],   32'h0000_0000);
    check("s6_inst0",  dlv_inst[bd], word_of(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
